// File: rtl/cpu_ctrl_pkg.sv
// Shared state encoding and instruction-type codes for the multicycle CPU control unit.
// The IRQ state member exists only when CPU_CTRL_IRQ_EN is defined.
package cpu_ctrl_pkg;

    localparam int unsigned STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_FETCH   = 4'd0;
    localparam logic [STATE_W-1:0] ST_DECODE  = 4'd1;
    localparam logic [STATE_W-1:0] ST_EXEC    = 4'd2;
    localparam logic [STATE_W-1:0] ST_STORE   = 4'd3;
    localparam logic [STATE_W-1:0] ST_LOAD_RD = 4'd4;
    localparam logic [STATE_W-1:0] ST_LOAD_WB = 4'd5;
    localparam logic [STATE_W-1:0] ST_BRANCH  = 4'd6;
    localparam logic [STATE_W-1:0] ST_JUMP    = 4'd7;
    localparam logic [STATE_W-1:0] ST_HALT    = 4'd8;
    localparam logic [STATE_W-1:0] ST_IRQ     = 4'd9;

    typedef enum logic [STATE_W-1:0] {
        FETCH   = ST_FETCH,
        DECODE  = ST_DECODE,
        EXEC    = ST_EXEC,
        STORE   = ST_STORE,
        LOAD_RD = ST_LOAD_RD,
        LOAD_WB = ST_LOAD_WB,
        BRANCH  = ST_BRANCH,
        JUMP    = ST_JUMP,
`ifdef CPU_CTRL_IRQ_EN
        IRQ     = ST_IRQ,
`endif
        HALT    = ST_HALT
    } state_t;

    localparam int unsigned INSTR_RTYPE  = 0;
    localparam int unsigned INSTR_STORE  = 1;
    localparam int unsigned INSTR_LOAD   = 2;
    localparam int unsigned INSTR_BRANCH = 3;
    localparam int unsigned INSTR_JUMP   = 4;
    localparam int unsigned INSTR_HALT   = 5;

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Decoder-side inputs and datapath enables of the CPU control unit.
// master: the control FSM; slave: the datapath / decoder side.
interface cpu_ctrl_fsm_if #(
    parameter int unsigned TYPE_W = 3
);
    logic [TYPE_W-1:0] instr_type;
    logic              cond_true;
    logic              stall;
    logic              resume;
    logic              irq;

    logic pc_enable;
    logic pc_load;
    logic pc_vec_sel;
    logic ir_enable;
    logic r_enable;
    logic alu_bus_en;
    logic reg_read;
    logic wrt_bram_en;
    logic irq_ack;
    logic illegal;
    logic halted;

    modport master (
        input  instr_type, cond_true, stall, resume, irq,
        output pc_enable, pc_load, pc_vec_sel, ir_enable, r_enable, alu_bus_en, reg_read,
               wrt_bram_en, irq_ack, illegal, halted
    );

    modport slave (
        output instr_type, cond_true, stall, resume, irq,
        input  pc_enable, pc_load, pc_vec_sel, ir_enable, r_enable, alu_bus_en, reg_read,
               wrt_bram_en, irq_ack, illegal, halted
    );
endinterface

// File: rtl/cpu_ctrl_wait_ctr.sv
// Load-latency counter: cleared on LOAD_RD entry, done after MEM_LAT cycles of enable.
module cpu_ctrl_wait_ctr #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // done is high during the last of the MEM_LAT LOAD_RD cycles
    assign done = (cnt_q == CNT_W'(MEM_LAT - 1));

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control FSM for the 16-bit CPU: fetch/decode/execute sequencing and datapath enables.
// Define CPU_CTRL_IRQ_EN to compile the interrupt-entry state.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned TYPE_W  = 3,
    parameter int unsigned MEM_LAT = 1
) (
    input logic            clk,
    input logic            reset,
    cpu_ctrl_fsm_if.master bus
);
    state_t            state_q, state_d;
    logic              to_fetch;
    logic              ctr_clr, ctr_en, ctr_done;
    logic [TYPE_W-1:0] instr_type;

    logic pc_enable, pc_load, pc_vec_sel, ir_enable, r_enable, alu_bus_en;
    logic reg_read, wrt_bram_en, irq_ack, illegal, halted;

    assign instr_type = bus.instr_type;

    cpu_ctrl_wait_ctr #(
        .MEM_LAT(MEM_LAT)
    ) u_wait_ctr (
        .clk  (clk),
        .reset(reset),
        .clr  (ctr_clr),
        .en   (ctr_en),
        .done (ctr_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        to_fetch    = 1'b0;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;
        pc_enable   = 1'b0;
        pc_load     = 1'b0;
        pc_vec_sel  = 1'b0;
        ir_enable   = 1'b0;
        r_enable    = 1'b0;
        alu_bus_en  = 1'b0;
        reg_read    = 1'b0;
        wrt_bram_en = 1'b0;
        irq_ack     = 1'b0;
        illegal     = 1'b0;
        halted      = 1'b0;

        case (state_q)
            FETCH: begin
                ir_enable  = 1'b1;
                alu_bus_en = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                alu_bus_en = 1'b1;
                case (instr_type)
                    TYPE_W'(INSTR_RTYPE):  state_d = EXEC;
                    TYPE_W'(INSTR_STORE):  state_d = STORE;
                    TYPE_W'(INSTR_LOAD): begin
                        state_d = LOAD_RD;
                        ctr_clr = 1'b1;
                    end
                    TYPE_W'(INSTR_BRANCH): state_d = BRANCH;
                    TYPE_W'(INSTR_JUMP):   state_d = JUMP;
                    TYPE_W'(INSTR_HALT):   state_d = HALT;
                    default: begin
                        // Straight back to FETCH, never redirected to an interrupt
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            EXEC: begin
                pc_enable  = 1'b1;
                r_enable   = 1'b1;
                alu_bus_en = 1'b1;
                to_fetch   = 1'b1;
            end
            STORE: begin
                pc_enable   = 1'b1;
                reg_read    = 1'b1;
                wrt_bram_en = 1'b1;
                to_fetch    = 1'b1;
            end
            LOAD_RD: begin
                reg_read = 1'b1;
                if (ctr_done) begin
                    state_d = LOAD_WB;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            LOAD_WB: begin
                pc_enable = 1'b1;
                r_enable  = 1'b1;
                reg_read  = 1'b1;
                to_fetch  = 1'b1;
            end
            BRANCH: begin
                pc_enable = 1'b1;
                pc_load   = bus.cond_true;
                to_fetch  = 1'b1;
            end
            JUMP: begin
                pc_enable = 1'b1;
                pc_load   = 1'b1;
                to_fetch  = 1'b1;
            end
            HALT: begin
                halted = 1'b1;
                if (bus.resume) begin
                    pc_enable = 1'b1;
                    state_d   = FETCH;
                end
`ifdef CPU_CTRL_IRQ_EN
                else if (bus.irq) begin
                    state_d = IRQ;
                end
`endif
            end
`ifdef CPU_CTRL_IRQ_EN
            IRQ: begin
                pc_enable  = 1'b1;
                pc_load    = 1'b1;
                pc_vec_sel = 1'b1;
                irq_ack    = 1'b1;
                state_d    = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase

        if (to_fetch) begin
            state_d = FETCH;
        end
`ifdef CPU_CTRL_IRQ_EN
        if (to_fetch && bus.irq) begin
            state_d = IRQ;
        end
`endif

        // Freeze: hold state and counter, suppress every side-effecting enable
        if (bus.stall) begin
            state_d     = state_q;
            ctr_clr     = 1'b0;
            ctr_en      = 1'b0;
            pc_enable   = 1'b0;
            ir_enable   = 1'b0;
            r_enable    = 1'b0;
            wrt_bram_en = 1'b0;
            irq_ack     = 1'b0;
            illegal     = 1'b0;
        end
    end

    assign bus.pc_enable   = pc_enable;
    assign bus.pc_load     = pc_load;
    assign bus.pc_vec_sel  = pc_vec_sel;
    assign bus.ir_enable   = ir_enable;
    assign bus.r_enable    = r_enable;
    assign bus.alu_bus_en  = alu_bus_en;
    assign bus.reg_read    = reg_read;
    assign bus.wrt_bram_en = wrt_bram_en;
    assign bus.irq_ack     = irq_ack;
    assign bus.illegal     = illegal;
    assign bus.halted      = halted;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed scenarios plus randomized instruction streams
// checked against a per-instruction cycle model of the control outputs.
module tb_cpu_ctrl_fsm;
    localparam int unsigned TYPE_W  = 3;
    localparam int unsigned MEM_LAT = 3;

    // {pc_enable, pc_load, pc_vec_sel, ir_enable, r_enable, alu_bus_en,
    //  reg_read, wrt_bram_en, irq_ack, illegal, halted}
    localparam logic [10:0] O_FETCH    = 11'b00010100000;
    localparam logic [10:0] O_DECODE   = 11'b00000100000;
    localparam logic [10:0] O_ILL      = 11'b00000100010;
    localparam logic [10:0] O_EXEC     = 11'b10001100000;
    localparam logic [10:0] O_STORE    = 11'b10000011000;
    localparam logic [10:0] O_LDRD     = 11'b00000010000;
    localparam logic [10:0] O_LDWB     = 11'b10001010000;
    localparam logic [10:0] O_BR0      = 11'b10000000000;
    localparam logic [10:0] O_BR1      = 11'b11000000000;
    localparam logic [10:0] O_HALT     = 11'b00000000001;
    localparam logic [10:0] O_HALT_RES = 11'b10000000001;
    localparam logic [10:0] O_IRQ      = 11'b11100000100;
    // stall keeps pc_load, pc_vec_sel, alu_bus_en, reg_read, halted
    localparam logic [10:0] STALL_KEEP = 11'b01100110001;

    typedef struct {
        logic [10:0]       vec;
        logic [TYPE_W-1:0] instr;
        logic              cond;
        logic              stall;
        logic              resume;
        logic              irq;
    } step_t;

    logic   clk   = 1'b0;
    logic   reset = 1'b0;
    int     checks = 0;
    int     errors = 0;
    step_t  seq_q[$];

    cpu_ctrl_fsm_if #(.TYPE_W(TYPE_W)) bus ();

    cpu_ctrl_fsm #(
        .TYPE_W (TYPE_W),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    function automatic logic [10:0] outs();
        return {bus.pc_enable, bus.pc_load, bus.pc_vec_sel, bus.ir_enable, bus.r_enable,
                bus.alu_bus_en, bus.reg_read, bus.wrt_bram_en, bus.irq_ack, bus.illegal,
                bus.halted};
    endfunction

    function automatic logic [10:0] expect_vec(input step_t s);
        return s.stall ? (s.vec & STALL_KEEP) : s.vec;
    endfunction

    task automatic push(input logic [10:0] vec, input int unsigned instr, input logic cond,
                        input logic stall, input logic resume, input logic irq);
        step_t s;
        s.vec    = vec;
        s.instr  = TYPE_W'(instr);
        s.cond   = cond;
        s.stall  = stall;
        s.resume = resume;
        s.irq    = irq;
        seq_q.push_back(s);
    endtask

    // Reference: cycle-by-cycle outputs of one instruction, no stalls
    task automatic build_instr(input int unsigned t, input logic cond, input int unsigned hwait);
        push(O_FETCH, t, cond, 1'b0, 1'b0, 1'b0);
        if (t > 5) begin
            push(O_ILL, t, cond, 1'b0, 1'b0, 1'b0);
            return;
        end
        push(O_DECODE, t, cond, 1'b0, 1'b0, 1'b0);
        case (t)
            0: push(O_EXEC, t, cond, 1'b0, 1'b0, 1'b0);
            1: push(O_STORE, t, cond, 1'b0, 1'b0, 1'b0);
            2: begin
                for (int k = 0; k < int'(MEM_LAT); k++) push(O_LDRD, t, cond, 1'b0, 1'b0, 1'b0);
                push(O_LDWB, t, cond, 1'b0, 1'b0, 1'b0);
            end
            3: push(cond ? O_BR1 : O_BR0, t, cond, 1'b0, 1'b0, 1'b0);
            4: push(O_BR1, t, cond, 1'b0, 1'b0, 1'b0);
            default: begin
                for (int k = 0; k < int'(hwait); k++) push(O_HALT, t, cond, 1'b0, 1'b0, 1'b0);
                push(O_HALT_RES, t, cond, 1'b0, 1'b1, 1'b0);
            end
        endcase
    endtask

    task automatic drive(input step_t s);
        @(negedge clk);
        bus.instr_type = s.instr;
        bus.cond_true  = s.cond;
        bus.stall      = s.stall;
        bus.resume     = s.resume;
        bus.irq        = s.irq;
        #1;
    endtask

    task automatic test_reset();
        seq_q.delete();
        build_instr(2, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(seq_q[i]);
            checks++;
            if (outs() !== seq_q[i].vec) begin
                errors++;
                $display("FAIL reset_pre[%0d]: got %b want %b", i, outs(), seq_q[i].vec);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (outs() !== O_FETCH) begin
            errors++;
            $display("FAIL reset_async: got %b want %b", outs(), O_FETCH);
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs() !== O_FETCH) begin
            errors++;
            $display("FAIL reset_hold: got %b want %b", outs(), O_FETCH);
        end
        reset = 1'b1;
        for (int i = 1; i < seq_q.size(); i++) begin
            drive(seq_q[i]);
            checks++;
            if (outs() !== seq_q[i].vec) begin
                errors++;
                $display("FAIL reset_after[%0d]: got %b want %b", i, outs(), seq_q[i].vec);
            end
        end
    endtask

    task automatic test_rtype_store();
        seq_q.delete();
        build_instr(0, 1'b0, 0);
        build_instr(1, 1'b0, 0);
        foreach (seq_q[i]) begin
            drive(seq_q[i]);
            checks++;
            if (outs() !== seq_q[i].vec) begin
                errors++;
                $display("FAIL rtype_store[%0d]: got %b want %b", i, outs(), seq_q[i].vec);
            end
        end
    endtask

    task automatic test_load();
        int n;
        seq_q.delete();
        build_instr(2, 1'b0, 0);
        foreach (seq_q[i]) begin
            drive(seq_q[i]);
            checks++;
            if (outs() !== seq_q[i].vec) begin
                errors++;
                $display("FAIL load_seq[%0d]: got %b want %b", i, outs(), seq_q[i].vec);
            end
        end
        // Measure FETCH-to-FETCH distance of a LOAD
        drive(seq_q[0]);
        n = 0;
        do begin
            drive(seq_q[1]);
            n++;
        end while (bus.ir_enable !== 1'b1 && n < 20);
        checks++;
        if (n != int'(3 + MEM_LAT)) begin
            errors++;
            $display("FAIL load_cycles: got %0d want %0d", n, 3 + MEM_LAT);
        end
        for (int i = 1; i < seq_q.size(); i++) begin
            drive(seq_q[i]);
            checks++;
            if (outs() !== seq_q[i].vec) begin
                errors++;
                $display("FAIL load_tail[%0d]: got %b want %b", i, outs(), seq_q[i].vec);
            end
        end
    endtask

    task automatic test_branch_illegal();
        seq_q.delete();
        build_instr(3, 1'b0, 0);
        build_instr(3, 1'b1, 0);
        build_instr(7, 1'b1, 0);
        build_instr(6, 1'b0, 0);
        build_instr(4, 1'b0, 0);
        foreach (seq_q[i]) begin
            drive(seq_q[i]);
            checks++;
            if (outs() !== seq_q[i].vec) begin
                errors++;
                $display("FAIL branch_illegal[%0d]: got %b want %b", i, outs(), seq_q[i].vec);
            end
        end
    endtask

    task automatic test_stall();
        seq_q.delete();
        push(O_FETCH, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(O_DECODE, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) push(O_EXEC, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(O_EXEC, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        // stall inside LOAD_RD must not advance the latency counter
        push(O_FETCH, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        push(O_DECODE, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        push(O_LDRD, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        push(O_LDRD, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        push(O_LDRD, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        push(O_LDRD, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        push(O_LDRD, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        push(O_LDWB, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        // stall beats resume in HALT
        push(O_FETCH, 5, 1'b0, 1'b1, 1'b0, 1'b0);
        push(O_FETCH, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        push(O_DECODE, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        push(O_HALT_RES, 5, 1'b0, 1'b1, 1'b1, 1'b1);
        push(O_HALT_RES, 5, 1'b0, 1'b0, 1'b1, 1'b0);
        foreach (seq_q[i]) begin
            drive(seq_q[i]);
            checks++;
            if (outs() !== expect_vec(seq_q[i])) begin
                errors++;
                $display("FAIL stall[%0d]: got %b want %b", i, outs(), expect_vec(seq_q[i]));
            end
        end
    endtask

    task automatic test_irq();
        seq_q.delete();
`ifdef CPU_CTRL_IRQ_EN
        push(O_FETCH, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(O_DECODE, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(O_EXEC, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(O_IRQ, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(O_FETCH, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        push(O_DECODE, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        push(O_HALT, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        push(O_HALT, 5, 1'b0, 1'b0, 1'b0, 1'b1);
        push(O_IRQ, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        push(O_FETCH, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        push(O_DECODE, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        push(O_HALT_RES, 5, 1'b0, 1'b0, 1'b1, 1'b1);
`else
        push(O_FETCH, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(O_DECODE, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(O_EXEC, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(O_FETCH, 5, 1'b0, 1'b0, 1'b0, 1'b1);
        push(O_DECODE, 5, 1'b0, 1'b0, 1'b0, 1'b1);
        push(O_HALT, 5, 1'b0, 1'b0, 1'b0, 1'b1);
        push(O_HALT_RES, 5, 1'b0, 1'b0, 1'b1, 1'b1);
`endif
        foreach (seq_q[i]) begin
            drive(seq_q[i]);
            checks++;
            if (outs() !== seq_q[i].vec) begin
                errors++;
                $display("FAIL irq[%0d]: got %b want %b", i, outs(), seq_q[i].vec);
            end
        end
    endtask

    task automatic test_random();
        step_t       s;
        int unsigned t;
        int          i;
        repeat (60) begin
            t = $urandom_range(0, 7);
            seq_q.delete();
            build_instr(t, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            i = 0;
            while (i < seq_q.size()) begin
                s       = seq_q[i];
                s.stall = ($urandom_range(0, 4) == 0);
                if (t != 5) s.resume = 1'($urandom_range(0, 1));
`ifndef CPU_CTRL_IRQ_EN
                s.irq = 1'($urandom_range(0, 1));
`endif
                drive(s);
                checks++;
                if (outs() !== expect_vec(s)) begin
                    errors++;
                    $display("FAIL random[t=%0d,%0d,stall=%0b]: got %b want %b", t, i, s.stall,
                             outs(), expect_vec(s));
                end
                if (!s.stall) i++;
            end
        end
    endtask

    initial begin
        bus.instr_type = '0;
        bus.cond_true  = 1'b0;
        bus.stall      = 1'b0;
        bus.resume     = 1'b0;
        bus.irq        = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (outs() !== O_FETCH) begin
            errors++;
            $display("FAIL reset_init: got %b want %b", outs(), O_FETCH);
        end
        @(posedge clk);
        #2 reset = 1'b1;

        test_reset();
        test_rtype_store();
        test_load();
        test_branch_illegal();
        test_stall();
        test_irq();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
